wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back sink of the MEM/WB pipeline register: consumes wb_wd/wb_wreg/wb_wdata (GPR write) and wb_whilo/wb_hi/wb_lo (HI/LO write).
- Holds the 32-entry general-purpose register file and the HI/LO pair.
- Supplies the ID stage with two GPR read ports and the EX stage with HI/LO values.
- Resolves read-after-write hazards internally: same-cycle WB bypass for GPR reads; MEM-then-WB forwarding for HI/LO reads.

Parameters:
- DATA_W, 32, width of GPR/HI/LO data (RegBus).
- ADDR_W, 5, GPR address width (RegAddrBus).
- NREGS, 32, number of GPRs; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- wb_wd  in  ADDR_W  GPR write address from MEM/WB.
- wb_wreg  in  1  GPR write enable.
- wb_wdata  in  DATA_W  GPR write data.
- wb_whilo_i  in  1  HI/LO write enable from MEM/WB.
- wb_hi_i  in  DATA_W  HI write data.
- wb_lo_i  in  DATA_W  LO write data.
- mem_whilo_i  in  1  HI/LO write enable of the instruction now in MEM (forwarding only).
- mem_hi_i  in  DATA_W  MEM-stage HI value.
- mem_lo_i  in  DATA_W  MEM-stage LO value.
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read address, port 1.
- rdata1  out  DATA_W  read data, port 1; combinational.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read address, port 2.
- rdata2  out  DATA_W  read data, port 2; combinational.
- hi_o  out  DATA_W  forwarded HI for EX; combinational.
- lo_o  out  DATA_W  forwarded LO for EX; combinational.

Behaviour:
- Reset
  - On a rising edge with rst=1: all NREGS GPRs cleared to 0; HI and LO cleared to 0; any write presented that cycle is discarded.
  - While rst=1: rdata1, rdata2, hi_o and lo_o are all 0.
- GPR write
  - On a rising edge with rst=0, wb_wreg=1 and wb_wd!=0: reg[wb_wd] <= wb_wdata.
  - Writes to address 0 are ignored; reg[0] always reads 0.
- GPR read, per port n, priority order:
  - rst=1 -> 0.
  - re_n=0 -> 0.
  - raddr_n=0 -> 0.
  - wb_wreg=1 and wb_wd==raddr_n -> wb_wdata (write-through bypass, zero-cycle latency).
  - Otherwise reg[raddr_n].
  - Ports are independent; both may address the same register, including the bypassed one.
- HI/LO write
  - On a rising edge with rst=0 and wb_whilo_i=1: HI <= wb_hi_i and LO <= wb_lo_i, always together.
  - wb_whilo_i=0 leaves both unchanged.
- HI/LO read (hi_o/lo_o), priority order:
  - rst=1 -> 0.
  - mem_whilo_i=1 -> mem_hi_i/mem_lo_i.
  - wb_whilo_i=1 -> wb_hi_i/wb_lo_i.
  - Otherwise stored HI/LO.
  - The MEM stage wins over WB because it holds the younger instruction.
- Latency
  - Written value is visible on reads in the same cycle via bypass.
  - From the cycle after the edge it is visible from storage.
- Simultaneous events
  - GPR write and HI/LO write in the same cycle are independent and both take effect.
  - Rst with a pending write: rst wins.
  - Reset mid-stream: state returns to 0 on the edge; pipeline registers upstream are cleared in the same edge, so no stale write follows.
- No X on outputs after the first reset edge; register contents before the first reset edge are don't-care.

Test Plan:
- Reset: assert rst 1 cycle with wb_wreg=1, wb_wd=5, wb_wdata=0xDEADBEEF -> after release, raddr1=5, re1=1 gives rdata1=0; hi_o=lo_o=0.
- Write/readback: write reg 3=0x12345678; next cycle re1=1, raddr1=3 -> rdata1=0x12345678; re1=0 -> rdata1=0.
- Bypass: wb_wreg=1, wb_wd=7, wb_wdata=0xA5A5A5A5 with raddr1=raddr2=7, re1=re2=1 in the same cycle -> both ports read 0xA5A5A5A5 before the edge.
- Zero register: write reg 0=0xFFFFFFFF, then read raddr1=0 -> 0; bypass path also returns 0.
- HI/LO forwarding:
  - Stored HI=1, LO=2.
  - wb_whilo_i=1 with wb_hi_i=3, wb_lo_i=4, and mem_whilo_i=1 with mem_hi_i=5, mem_lo_i=6 -> hi_o=5, lo_o=6.
  - Drop mem_whilo_i -> hi_o=3, lo_o=4.
  - After the edge with both enables low -> hi_o=3, lo_o=4 from storage.
- Concurrent writes: same cycle, GPR write reg 31=0x1 and HI/LO write HI=0xAA, LO=0xBB -> next cycle reg31=0x1, hi_o=0xAA, lo_o=0xBB.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 GPRs plus HI/LO, with WB bypass on GPR reads and MEM/WB forwarding on HI/LO.
// Reads are combinational and take zero cycles; writes commit on the rising edge. No backpressure: every write is taken.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo_i,
    input  logic [DATA_W-1:0] wb_hi_i,
    input  logic [DATA_W-1:0] wb_lo_i,
    input  logic              mem_whilo_i,
    input  logic [DATA_W-1:0] mem_hi_i,
    input  logic [DATA_W-1:0] mem_lo_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_wreg && (wb_wd != '0)) begin
            regs[wb_wd] <= wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wb_whilo_i) begin
            hi_q <= wb_hi_i;
            lo_q <= wb_lo_i;
        end
    end

    // Write-through bypass lets ID see a value being written back this cycle.
    always_comb begin
        rdata1 = '0;
        if (rst || !re1 || (raddr1 == '0)) begin
            rdata1 = '0;
        end else if (wb_wreg && (wb_wd == raddr1)) begin
            rdata1 = wb_wdata;
        end else begin
            rdata1 = regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst || !re2 || (raddr2 == '0)) begin
            rdata2 = '0;
        end else if (wb_wreg && (wb_wd == raddr2)) begin
            rdata2 = wb_wdata;
        end else begin
            rdata2 = regs[raddr2];
        end
    end

    // MEM holds the younger instruction, so its HI/LO take precedence over WB.
    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (mem_whilo_i) begin
            hi_o = mem_hi_i;
            lo_o = mem_lo_i;
        end else if (wb_whilo_i) begin
            hi_o = wb_hi_i;
            lo_o = wb_lo_i;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed checks of the write-back register file: reset, writes, bypass, r0, HI/LO forwarding.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo_i;
    logic [31:0] wb_hi_i;
    logic [31:0] wb_lo_i;
    logic        mem_whilo_i;
    logic [31:0] mem_hi_i;
    logic [31:0] mem_lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_wd       (wb_wd),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata),
        .wb_whilo_i  (wb_whilo_i),
        .wb_hi_i     (wb_hi_i),
        .wb_lo_i     (wb_lo_i),
        .mem_whilo_i (mem_whilo_i),
        .mem_hi_i    (mem_hi_i),
        .mem_lo_i    (mem_lo_i),
        .re1         (re1),
        .raddr1      (raddr1),
        .rdata1      (rdata1),
        .re2         (re2),
        .raddr2      (raddr2),
        .rdata2      (rdata2),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Step across one rising edge; inputs are then changed 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wb_wreg = 1'b1; wb_wd = 5'd5; wb_wdata = 32'hDEADBEEF;
        wb_whilo_i = 1'b1; wb_hi_i = 32'h11; wb_lo_i = 32'h22;
        mem_whilo_i = 1'b1; mem_hi_i = 32'h33; mem_lo_i = 32'h44;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;

        tick();
        #1;
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rdata2", rdata2, 32'h0);
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);

        rst = 1'b0; wb_wreg = 1'b0; wb_whilo_i = 1'b0; mem_whilo_i = 1'b0;
        #1;
        check("post_rst_reg5", rdata1, 32'h0);
        check("post_rst_hi", hi_o, 32'h0);
        check("post_rst_lo", lo_o, 32'h0);

        // Write reg 3; bypass is visible before the edge
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h12345678; raddr1 = 5'd3;
        #1;
        check("wr3_bypass", rdata1, 32'h12345678);
        tick();
        wb_wreg = 1'b0; wb_wdata = 32'h0;
        #1;
        check("wr3_stored", rdata1, 32'h12345678);
        re1 = 1'b0;
        #1;
        check("re1_off", rdata1, 32'h0);
        re1 = 1'b1;

        // Bypass on both ports at once
        wb_wreg = 1'b1; wb_wd = 5'd7; wb_wdata = 32'hA5A5A5A5;
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        check("byp_port1", rdata1, 32'hA5A5A5A5);
        check("byp_port2", rdata2, 32'hA5A5A5A5);
        re2 = 1'b0;
        #1;
        check("byp_re2_off", rdata2, 32'h0);
        re2 = 1'b1;
        tick();
        wb_wreg = 1'b0;
        raddr1 = 5'd3;
        #1;
        check("indep_port1", rdata1, 32'h12345678);
        check("indep_port2", rdata2, 32'hA5A5A5A5);

        // Bypass must not fire for an address mismatch
        wb_wreg = 1'b1; wb_wd = 5'd9; wb_wdata = 32'hCAFEF00D;
        #1;
        check("nobyp_mismatch", rdata1, 32'h12345678);
        tick();
        wb_wreg = 1'b0;

        // Register zero
        wb_wreg = 1'b1; wb_wd = 5'd0; wb_wdata = 32'hFFFFFFFF;
        raddr1 = 5'd0; raddr2 = 5'd0;
        #1;
        check("r0_bypass", rdata1, 32'h0);
        tick();
        wb_wreg = 1'b0;
        #1;
        check("r0_stored1", rdata1, 32'h0);
        check("r0_stored2", rdata2, 32'h0);

        // HI/LO: store 1/2, then forwarding priority
        wb_whilo_i = 1'b1; wb_hi_i = 32'h1; wb_lo_i = 32'h2;
        tick();
        wb_whilo_i = 1'b0;
        #1;
        check("hilo_st_hi", hi_o, 32'h1);
        check("hilo_st_lo", lo_o, 32'h2);
        wb_whilo_i = 1'b1; wb_hi_i = 32'h3; wb_lo_i = 32'h4;
        mem_whilo_i = 1'b1; mem_hi_i = 32'h5; mem_lo_i = 32'h6;
        #1;
        check("fwd_mem_hi", hi_o, 32'h5);
        check("fwd_mem_lo", lo_o, 32'h6);
        mem_whilo_i = 1'b0;
        #1;
        check("fwd_wb_hi", hi_o, 32'h3);
        check("fwd_wb_lo", lo_o, 32'h4);
        tick();
        wb_whilo_i = 1'b0; wb_hi_i = 32'h0; wb_lo_i = 32'h0;
        #1;
        check("hilo_st2_hi", hi_o, 32'h3);
        check("hilo_st2_lo", lo_o, 32'h4);

        // Concurrent GPR and HI/LO writes
        wb_wreg = 1'b1; wb_wd = 5'd31; wb_wdata = 32'h1;
        wb_whilo_i = 1'b1; wb_hi_i = 32'hAA; wb_lo_i = 32'hBB;
        tick();
        wb_wreg = 1'b0; wb_whilo_i = 1'b0; wb_wdata = 32'h0;
        raddr1 = 5'd31; raddr2 = 5'd3;
        #1;
        check("conc_r31", rdata1, 32'h1);
        check("conc_hi", hi_o, 32'hAA);
        check("conc_lo", lo_o, 32'hBB);
        check("conc_r3_kept", rdata2, 32'h12345678);

        // Reset mid-stream with a pending write: reset wins
        rst = 1'b1;
        wb_wreg = 1'b1; wb_wd = 5'd3; wb_wdata = 32'h77777777;
        wb_whilo_i = 1'b1; wb_hi_i = 32'h99; wb_lo_i = 32'h88;
        tick();
        rst = 1'b0; wb_wreg = 1'b0; wb_whilo_i = 1'b0;
        #1;
        check("rst2_r31", rdata1, 32'h0);
        check("rst2_r3", rdata2, 32'h0);
        check("rst2_hi", hi_o, 32'h0);
        check("rst2_lo", lo_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
